eda_output_streamer: RTL

Downstream consumer of the output mask RAM in the regional-maxima pipeline. When processing of an image completes, it snapshots the full M×N result mask and requests a mask clear so the RAM is ready for the next image. It then serialises the snapshot in raster order onto a valid/ready output stream of OUT_WIDTH-bit beats.

---
 rtl/eda_stream_pkg.sv | 26 ++
 rtl/eda_output_streamer.sv | 105 ++++++++++
 2 files changed

// File: rtl/eda_stream_pkg.sv
// Shared types and sizing helpers for the mask output streamer.
// Sizing is derived from the mask geometry and the beat width.
package eda_stream_pkg;

    localparam int CFG_M = 4;
    localparam int CFG_N = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

    function automatic int total_bits(input int m, input int n);
        return m * n;
    endfunction

    function automatic int num_beats(input int m, input int n, input int w);
        return (m * n + w - 1) / w;
    endfunction

    // A single-beat image still needs a 1-bit counter.
    function automatic int cnt_width(input int m, input int n, input int w);
        return (num_beats(m, n, w) > 1) ? $clog2(num_beats(m, n, w)) : 1;
    endfunction

endpackage

// File: rtl/eda_output_streamer.sv
// Snapshots the finished result mask, requests a mask clear, and streams the
// snapshot in raster order as OUT_WIDTH-bit valid/ready beats.
module eda_output_streamer
    import eda_stream_pkg::*;
#(
    parameter int M         = CFG_M,
    parameter int N         = CFG_N,
    parameter int OUT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [M-1:0][N-1:0]    matrix_in,
    output logic                   clear_req,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam int TOTAL_BITS = total_bits(M, N);
    localparam int NUM_BEATS  = num_beats(M, N, OUT_WIDTH);
    localparam int CNT_W      = cnt_width(M, N, OUT_WIDTH);
    localparam int SNAP_W     = NUM_BEATS * OUT_WIDTH;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);
    localparam logic SINGLE_BEAT = (NUM_BEATS == 32'd1);

    stream_state_e     state_r, state_s;
    logic [SNAP_W-1:0] snap_r, snap_s;
    logic [CNT_W-1:0]  beat_r, beat_s;
    logic              clear_req_r, clear_req_s;
    logic              done_r, done_s;
    logic              last_r, last_s;

    // Next-state, snapshot shift, beat counter and pulse generation.
    always_comb begin
        state_s     = state_r;
        snap_s      = snap_r;
        beat_s      = beat_r;
        clear_req_s = 1'b0;
        done_s      = 1'b0;
        last_s      = last_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s     = STREAM;
                    snap_s      = SNAP_W'(matrix_in);
                    beat_s      = '0;
                    clear_req_s = 1'b1;
                    last_s      = SINGLE_BEAT;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    // Shifting on the final beat too leaves the snapshot zeroed in IDLE.
                    snap_s = snap_r >> OUT_WIDTH;
                    if (beat_r == LAST_BEAT) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                        last_s  = 1'b0;
                    end else begin
                        beat_s = beat_r + CNT_W'(1);
                        last_s = ((beat_r + CNT_W'(1)) == LAST_BEAT);
                    end
                end else begin
                    state_s = STREAM;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            snap_r      <= '0;
            beat_r      <= '0;
            clear_req_r <= 1'b0;
            done_r      <= 1'b0;
            last_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            snap_r      <= snap_s;
            beat_r      <= beat_s;
            clear_req_r <= clear_req_s;
            done_r      <= done_s;
            last_r      <= last_s;
        end
    end

    assign clear_req = clear_req_r;
    assign out_valid = (state_r == STREAM);
    assign busy      = (state_r == STREAM);
    assign out_data  = snap_r[OUT_WIDTH-1:0];
    assign out_last  = last_r;
    assign done      = done_r;

endmodule
